// File: rtl/soc_pkg.sv
// ============================================================================
// Module  : soc_pkg
// Brief   : Shared write-bus widths, entry record and sizing helpers.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package soc_pkg;

    localparam int DEF_ADDR_WID   = 32;
    localparam int DEF_DATA_WID   = 32;
    localparam int DEF_FIFO_DEPTH = 8;
    localparam int DEF_OCC_WID    = $clog2(DEF_FIFO_DEPTH + 1);

    typedef struct packed {
        logic [DEF_ADDR_WID-1:0] addr;
        logic [DEF_DATA_WID-1:0] data;
    } wr_entry_t;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module  : sync_fifo
// Brief   : Single-clock FIFO, first-word-through head, unreset storage.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             din,
    input  logic                         pop,
    output logic [WIDTH-1:0]             dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_WID = $clog2(DEPTH);
    localparam int OCC_WID = $clog2(DEPTH + 1);
    localparam logic [PTR_WID-1:0] PTR_ONE   = {{(PTR_WID-1){1'b0}}, 1'b1};
    localparam logic [OCC_WID-1:0] OCC_DEPTH = OCC_WID'(DEPTH);

    logic [WIDTH-1:0]   mem [DEPTH];
    logic [PTR_WID-1:0] wr_ptr;
    logic [PTR_WID-1:0] rd_ptr;
    logic               do_push;
    logic               do_pop;

    assign empty   = (count == '0);
    assign full    = (count == OCC_DEPTH);
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot a full-FIFO push needs
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            count <= count + {{(OCC_WID-1){1'b0}}, do_push}
                           - {{(OCC_WID-1){1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

`default_nettype wire

// File: rtl/mem_wr_sink.sv
// ============================================================================
// Module  : mem_wr_sink
// Brief   : Buffers core-bus writes and drains them to memory via valid/ready.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_wr_sink
    import soc_pkg::*;
#(
    parameter int ADDR_WID     = DEF_ADDR_WID,
    parameter int DATA_WID     = DEF_DATA_WID,
    parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
    parameter int STALL_MARGIN = 2,
    parameter int CNT_WID      = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mem_we,
    input  logic [ADDR_WID-1:0] mem_addr,
    input  logic [DATA_WID-1:0] mem_data,
    output logic                bus_stall,
    output logic                wr_valid,
    output logic [ADDR_WID-1:0] wr_addr,
    output logic [DATA_WID-1:0] wr_data,
    input  logic                wr_ready,
    output logic                ovf_err,
    output logic [CNT_WID-1:0]  wr_cnt,
    output logic                idle
);

    localparam int OCC_WID = $clog2(FIFO_DEPTH + 1);
    localparam int ENT_WID = ADDR_WID + DATA_WID;
    localparam logic [OCC_WID-1:0] STALL_LEVEL = OCC_WID'(FIFO_DEPTH - STALL_MARGIN);
    localparam logic [CNT_WID-1:0] CNT_ONE     = {{(CNT_WID-1){1'b0}}, 1'b1};

    logic               push;
    logic               pop;
    logic               drop;
    logic               full;
    logic               empty;
    logic [OCC_WID-1:0] occ;
    logic [OCC_WID-1:0] occ_next;
    logic [ENT_WID-1:0] head;

    assign pop      = ~empty & wr_ready;
    assign push     = mem_we & (~full | pop);
    assign drop     = mem_we & full & ~pop;
    assign occ_next = occ + {{(OCC_WID-1){1'b0}}, push}
                          - {{(OCC_WID-1){1'b0}}, pop};

    sync_fifo #(
        .WIDTH (ENT_WID),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   ({mem_addr, mem_data}),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (occ)
    );

    // Head is masked while empty so unreset storage never reaches the port
    assign wr_valid = ~empty;
    assign wr_addr  = empty ? '0 : head[ENT_WID-1 -: ADDR_WID];
    assign wr_data  = empty ? '0 : head[DATA_WID-1:0];
    assign idle     = empty & ~mem_we;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_stall <= 1'b0;
            ovf_err   <= 1'b0;
            wr_cnt    <= '0;
        end else begin
            bus_stall <= (occ_next >= STALL_LEVEL);
            if (drop) ovf_err <= 1'b1;
            if (push) wr_cnt  <= wr_cnt + CNT_ONE;
        end
    end

endmodule

`default_nettype wire
